sysa_sched: RTL

- Single-clock sequencer that owns one systolic array (sysa) instance and runs one complete tile operation per start command.
- Per tile: accepts an N x N weight tile and an N x N input tile over valid/ready streams. Clears the array, feeds skewed input words and deskews the column outputs into a result buffer. Then streams the N*N results out in row-major order.
- Sits between the bus-side loader FSM and sysa. It replaces ad-hoc counter sequencing with a single, checkable schedule.

---
 rtl/sysa_sched.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sysa_sched.sv
// sysa_sched: single-clock sequencer around one N x N systolic array.
// One start command runs one tile. The block loads N weight rows (skipped
// when reuse_w is set and weights are already held) and N input rows.
// It clears the array, runs it with skewed input words while deskewing
// column outputs into a result buffer, then streams N*N results
// row-major.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, reuse_w        tile command (IDLE only), weight-reuse qualifier
//   busy, done            state != IDLE, one-cycle pulse after last result
//   w_valid/w_ready/w_data     weight row stream (lane c at [c*DW +: DW])
//   in_valid/in_ready/in_data  input row stream  (lane c at [c*DW +: DW])
//   sa_clr, sa_en, sa_w, sa_in array control, weight tile, skewed input word
//   sa_out                array column outputs (column k at [k*AW +: AW])
//   r_valid/r_ready/r_data/r_last  result stream, r_last on index N*N-1
module sysa_sched #(
    parameter int N       = 3,
    parameter int DW      = 8,
    parameter int AW      = 16,
    parameter int OUT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reuse_w,
    output logic              busy,
    output logic              done,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DW*N-1:0]   w_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW*N-1:0]   in_data,
    output logic              sa_clr,
    output logic              sa_en,
    output logic [DW*N*N-1:0] sa_w,
    output logic [DW*N-1:0]   sa_in,
    input  logic [AW*N-1:0]   sa_out,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [AW-1:0]     r_data,
    output logic              r_last
);
    localparam int NN   = N * N;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int TMAX = OUT_LAT + 2 * N - 2;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, CLEAR, RUN, OUT} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       w_cnt_q, w_cnt_d, i_cnt_q, i_cnt_d;
    logic [TW-1:0]       t_q, t_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                w_loaded_q, w_loaded_d;
    logic                done_q, done_d;
    logic [DW*N*N-1:0]   w_q;
    logic [DW-1:0]       x_q [N][N];
    logic [AW-1:0]       res_q [NN];

    always_comb begin
        state_d    = state_q;
        w_cnt_d    = w_cnt_q;
        i_cnt_d    = i_cnt_q;
        t_d        = t_q;
        idx_d      = idx_q;
        w_loaded_d = w_loaded_q;
        done_d     = 1'b0;
        w_ready    = 1'b0;
        in_ready   = 1'b0;
        sa_en      = 1'b0;
        r_valid    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (reuse_w && w_loaded_q) begin
                        state_d = LOAD_I;
                        i_cnt_d = '0;
                    end else begin
                        state_d = LOAD_W;
                        w_cnt_d = '0;
                    end
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    if (w_cnt_q == CW'(N - 1)) begin
                        state_d    = LOAD_I;
                        w_cnt_d    = '0;
                        i_cnt_d    = '0;
                        w_loaded_d = 1'b1;
                    end else begin
                        w_cnt_d = w_cnt_q + CW'(1);
                    end
                end
            end
            LOAD_I: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (i_cnt_q == CW'(N - 1)) begin
                        state_d = CLEAR;
                        i_cnt_d = '0;
                    end else begin
                        i_cnt_d = i_cnt_q + CW'(1);
                    end
                end
            end
            CLEAR: begin
                state_d = RUN;
                t_d     = '0;
            end
            RUN: begin
                sa_en = 1'b1;
                if (t_q == TW'(TMAX)) begin
                    state_d = OUT;
                    t_d     = '0;
                    idx_d   = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            OUT: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    if (idx_q == IW'(NN - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset wins over whatever state is still registered this cycle.
        if (rst) begin
            w_ready  = 1'b0;
            in_ready = 1'b0;
            sa_en    = 1'b0;
            r_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            w_cnt_q    <= '0;
            i_cnt_q    <= '0;
            t_q        <= '0;
            idx_q      <= '0;
            w_loaded_q <= 1'b0;
            done_q     <= 1'b0;
            w_q        <= '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    x_q[r][c] <= '0;
            for (int i = 0; i < NN; i++)
                res_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            w_cnt_q    <= w_cnt_d;
            i_cnt_q    <= i_cnt_d;
            t_q        <= t_d;
            idx_q      <= idx_d;
            w_loaded_q <= w_loaded_d;
            done_q     <= done_d;
            if (w_ready && w_valid)
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        if (int'(w_cnt_q) == r)
                            w_q[(r*N+c)*DW +: DW] <= w_data[c*DW +: DW];
            if (in_ready && in_valid)
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        if (int'(i_cnt_q) == r)
                            x_q[r][c] <= in_data[c*DW +: DW];
            // Deskew: row r of column k leaves the array at t = r + OUT_LAT + k.
            if (state_q == RUN)
                for (int r = 0; r < N; r++)
                    for (int k = 0; k < N; k++)
                        if (int'(t_q) == r + OUT_LAT + k)
                            res_q[r*N+k] <= sa_out[k*AW +: AW];
        end
    end

    // Skew: lane j carries row t-j, so row i enters lane j at t = i + j.
    always_comb begin
        sa_in = '0;
        if (state_q == RUN && !rst)
            for (int j = 0; j < N; j++)
                for (int i = 0; i < N; i++)
                    if (int'(t_q) == i + j)
                        sa_in[j*DW +: DW] = x_q[i][j];
    end

    always_comb begin
        r_data = '0;
        if (state_q == OUT && !rst)
            r_data = res_q[idx_q];
    end

    assign busy   = !rst && (state_q != IDLE);
    assign done   = done_q && !rst;
    assign sa_clr = rst || (state_q == CLEAR);
    assign sa_w   = w_q;
    assign r_last = !rst && (state_q == OUT) && (idx_q == IW'(NN - 1));

endmodule
